// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : DEPTH-entry byte FIFO with a write sequencer that feeds the
//            UART transceiver's transmit side, paced by its ready flag.
//            Optional macro UART_TX_FIFO_OVERFLOW_CNT_EN enables the
//            saturating dropped-push counter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              i_Clk_12MHz,
    input  logic              i_Reset,
    input  logic [7:0]        i_Push_Data,
    input  logic              i_Push_Valid,
    output logic              o_Push_Ready,
    output logic [7:0]        o_Data_In,
    output logic              o_Wr_En,
    input  logic              i_Tx_Ready,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Empty,
    output logic [7:0]        o_Overflow_Count
);

    localparam int                     c_TIMEOUT_W  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ADDR_W:0]        c_FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_TIMEOUT_W-1:0] c_ACK_LIMIT  = c_TIMEOUT_W'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    logic [7:0]              r_mem [DEPTH];
    logic [ADDR_W-1:0]       r_wr_ptr;
    logic [ADDR_W-1:0]       r_rd_ptr;
    logic [ADDR_W:0]         r_count;
    logic [c_TIMEOUT_W-1:0]  r_timeout;
    logic                    w_push;
    logic                    w_pop;

    assign o_Count      = r_count;
    assign o_Empty      = (r_count == '0);
    // Ready comes from the pre-edge count, so a full FIFO never admits a
    // push on the same edge as a pop.
    assign o_Push_Ready = (r_count != c_FULL_COUNT);

    assign w_push = i_Push_Valid && o_Push_Ready;
    assign w_pop  = (r_state == S_IDLE) && !o_Empty && i_Tx_Ready;

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge i_Clk_12MHz) begin
        if (w_push && !i_Reset) begin
            r_mem[r_wr_ptr] <= i_Push_Data;
        end
    end

    always_ff @(posedge i_Clk_12MHz) begin
        if (i_Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_Clk_12MHz) begin
        if (i_Reset) begin
            r_state   <= S_IDLE;
            o_Wr_En   <= 1'b0;
            o_Data_In <= 8'h00;
            r_timeout <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_Wr_En <= 1'b0;
                    if (w_pop) begin
                        o_Data_In <= r_mem[r_rd_ptr];
                        o_Wr_En   <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    o_Wr_En   <= 1'b0;
                    r_timeout <= '0;
                    r_state   <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    o_Wr_En <= 1'b0;
                    if (!i_Tx_Ready) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_timeout == c_ACK_LIMIT) begin
                        // Transceiver never went busy: strobe the same byte again.
                        o_Wr_En <= 1'b1;
                        r_state <= S_LOAD;
                    end else begin
                        r_timeout <= r_timeout + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    o_Wr_En <= 1'b0;
                    if (i_Tx_Ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    o_Wr_En <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVERFLOW_CNT_EN
    logic [7:0] r_overflow_count;

    always_ff @(posedge i_Clk_12MHz) begin
        if (i_Reset) begin
            r_overflow_count <= 8'h00;
        end else if (i_Push_Valid && !o_Push_Ready && (r_overflow_count != 8'hFF)) begin
            r_overflow_count <= r_overflow_count + 8'h01;
        end
    end

    assign o_Overflow_Count = r_overflow_count;
`else
    assign o_Overflow_Count = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo using a queue-based model
//            of the byte stream and a simple transceiver ready model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH       = 16;
    localparam int ADDR_W      = 4;
    localparam int ACK_TIMEOUT = 15;

    logic              i_Clk_12MHz = 1'b0;
    logic              i_Reset     = 1'b1;
    logic [7:0]        i_Push_Data = 8'h00;
    logic              i_Push_Valid = 1'b0;
    logic              o_Push_Ready;
    logic [7:0]        o_Data_In;
    logic              o_Wr_En;
    logic              i_Tx_Ready  = 1'b1;
    logic [ADDR_W:0]   o_Count;
    logic              o_Empty;
    logic [7:0]        o_Overflow_Count;

    int n_checks = 0;
    int n_fail   = 0;
    int ovf_model = 0;
    logic [7:0] fifo_q[$];

    uart_tx_fifo #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .i_Clk_12MHz      (i_Clk_12MHz),
        .i_Reset          (i_Reset),
        .i_Push_Data      (i_Push_Data),
        .i_Push_Valid     (i_Push_Valid),
        .o_Push_Ready     (o_Push_Ready),
        .o_Data_In        (o_Data_In),
        .o_Wr_En          (o_Wr_En),
        .i_Tx_Ready       (i_Tx_Ready),
        .o_Count          (o_Count),
        .o_Empty          (o_Empty),
        .o_Overflow_Count (o_Overflow_Count)
    );

    always #5 i_Clk_12MHz = ~i_Clk_12MHz;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge i_Clk_12MHz);
        @(negedge i_Clk_12MHz);
    endtask

    function automatic logic [7:0] exp_ovf();
`ifdef UART_TX_FIFO_OVERFLOW_CNT_EN
        return (ovf_model > 255) ? 8'hFF : 8'(ovf_model);
`else
        return 8'h00;
`endif
    endfunction

    // Brings an empty FIFO's sequencer back to idle with the transceiver ready.
    task automatic recover();
        i_Push_Valid = 1'b0;
        i_Tx_Ready   = 1'b0;
        tick(); tick(); tick();
        i_Tx_Ready   = 1'b1;
        tick(); tick();
    endtask

    task automatic test_reset();
        i_Reset = 1'b1; i_Push_Valid = 1'b0; i_Tx_Ready = 1'b1;
        tick(); tick();
        ovf_model = 0;
        n_checks++; if (o_Count !== 5'd0)   begin n_fail++; $display("FAIL reset_count: got %0d expected 0", o_Count); end
        n_checks++; if (o_Empty !== 1'b1)   begin n_fail++; $display("FAIL reset_empty: got %b expected 1", o_Empty); end
        n_checks++; if (o_Push_Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_Push_Ready); end
        n_checks++; if (o_Wr_En !== 1'b0)   begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", o_Wr_En); end
        n_checks++; if (o_Data_In !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", o_Data_In); end
        n_checks++; if (o_Overflow_Count !== 8'h00) begin n_fail++; $display("FAIL reset_ovf: got %h expected 00", o_Overflow_Count); end
        i_Reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] d;
        d = 8'($urandom);
        i_Tx_Ready = 1'b1; i_Push_Data = d; i_Push_Valid = 1'b1;
        tick();
        i_Push_Valid = 1'b0;
        n_checks++; if (o_Wr_En !== 1'b0) begin n_fail++; $display("FAIL single_early_wr: got %b expected 0", o_Wr_En); end
        n_checks++; if (o_Count !== 5'd1) begin n_fail++; $display("FAIL single_count1: got %0d expected 1", o_Count); end
        tick();
        n_checks++; if (o_Wr_En !== 1'b1) begin n_fail++; $display("FAIL single_wr: got %b expected 1", o_Wr_En); end
        n_checks++; if (o_Data_In !== d)  begin n_fail++; $display("FAIL single_data: got %h expected %h", o_Data_In, d); end
        n_checks++; if (o_Count !== 5'd0) begin n_fail++; $display("FAIL single_count0: got %0d expected 0", o_Count); end
        n_checks++; if (o_Empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b expected 1", o_Empty); end
        i_Tx_Ready = 1'b0;
        tick();
        n_checks++; if (o_Wr_En !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %b expected 0", o_Wr_En); end
        recover();
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] exp_d;
        int cnt = 0, peak = 0, pulses = 0, busy = 0, sent = 0;
        logic pv, pr, ptx, prev_wr;
        prev_wr = 1'b0;
        i_Tx_Ready = 1'b1;
        for (int cyc = 0; cyc < 800 && pulses < 16; cyc++) begin
            if (sent < 16) begin
                i_Push_Data = 8'($urandom); i_Push_Valid = 1'b1;
            end else begin
                i_Push_Valid = 1'b0;
            end
            pv = i_Push_Valid; pr = o_Push_Ready; ptx = i_Tx_Ready;
            n_checks++; if (o_Push_Ready !== (cnt != DEPTH)) begin n_fail++; $display("FAIL b2b_ready: got %b expected %b", o_Push_Ready, cnt != DEPTH); end
            tick();
            if (pv && pr) begin q.push_back(i_Push_Data); cnt++; sent++; end
            if (o_Wr_En === 1'b1) begin
                n_checks++; if (ptx !== 1'b1) begin n_fail++; $display("FAIL b2b_pulse_while_busy: got tx_ready %b expected 1", ptx); end
                n_checks++; if (prev_wr !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_width: got 2+ cycles expected 1"); end
                if (q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL b2b_extra_pulse: got data %h expected none", o_Data_In);
                end else begin
                    exp_d = q.pop_front();
                    n_checks++; if (o_Data_In !== exp_d) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", o_Data_In, exp_d); end
                    cnt--;
                end
                pulses++;
                busy = 20;
            end
            prev_wr = o_Wr_En;
            n_checks++; if (o_Count !== (ADDR_W+1)'(cnt)) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", o_Count, cnt); end
            if (cnt > peak) peak = cnt;
            if (busy > 0) begin i_Tx_Ready = 1'b0; busy--; end else i_Tx_Ready = 1'b1;
        end
        n_checks++; if (pulses != 16) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 16", pulses); end
        n_checks++; if (peak < 15 || peak > 16) begin n_fail++; $display("FAIL b2b_peak: got %0d expected 15..16", peak); end
        n_checks++; if (o_Empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b expected 1", o_Empty); end
        recover();
    endtask

    task automatic test_overflow();
        int cnt = 0;
        int attempts;
        logic pr;
        attempts = 17 + int'($urandom_range(0, 3));
        fifo_q.delete();
        i_Tx_Ready = 1'b0;
        for (int a = 0; a < attempts; a++) begin
            i_Push_Valid = 1'b1; i_Push_Data = 8'($urandom);
            pr = o_Push_Ready;
            n_checks++; if (o_Push_Ready !== (cnt != DEPTH)) begin n_fail++; $display("FAIL ovf_ready: got %b expected %b at push %0d", o_Push_Ready, cnt != DEPTH, a); end
            tick();
            if (pr) begin fifo_q.push_back(i_Push_Data); cnt++; end else ovf_model++;
            n_checks++; if (o_Count !== (ADDR_W+1)'(cnt)) begin n_fail++; $display("FAIL ovf_count: got %0d expected %0d", o_Count, cnt); end
        end
        i_Push_Valid = 1'b0;
        n_checks++; if (o_Count !== 5'd16) begin n_fail++; $display("FAIL ovf_full_count: got %0d expected 16", o_Count); end
        n_checks++; if (o_Push_Ready !== 1'b0) begin n_fail++; $display("FAIL ovf_full_ready: got %b expected 0", o_Push_Ready); end
        n_checks++; if (o_Wr_En !== 1'b0) begin n_fail++; $display("FAIL ovf_wr_en: got %b expected 0", o_Wr_En); end
        n_checks++; if (o_Overflow_Count !== exp_ovf()) begin n_fail++; $display("FAIL ovf_counter: got %0d expected %0d", o_Overflow_Count, exp_ovf()); end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_d;
        bit seen;
        i_Tx_Ready = 1'b1; i_Push_Valid = 1'b1; i_Push_Data = 8'($urandom);
        tick();
        ovf_model++;
        exp_d = fifo_q.pop_front();
        n_checks++; if (o_Count !== 5'd15) begin n_fail++; $display("FAIL fullpop_count: got %0d expected 15", o_Count); end
        n_checks++; if (o_Push_Ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_ready: got %b expected 1", o_Push_Ready); end
        n_checks++; if (o_Wr_En !== 1'b1) begin n_fail++; $display("FAIL fullpop_wr: got %b expected 1", o_Wr_En); end
        n_checks++; if (o_Data_In !== exp_d) begin n_fail++; $display("FAIL fullpop_data: got %h expected %h", o_Data_In, exp_d); end
        i_Tx_Ready = 1'b0; i_Push_Data = 8'($urandom);
        tick();
        fifo_q.push_back(i_Push_Data);
        n_checks++; if (o_Count !== 5'd16) begin n_fail++; $display("FAIL fullpop_refill: got %0d expected 16", o_Count); end
        i_Push_Valid = 1'b0;
        tick();
        n_checks++; if (o_Overflow_Count !== exp_ovf()) begin n_fail++; $display("FAIL fullpop_ovf: got %0d expected %0d", o_Overflow_Count, exp_ovf()); end
        while (fifo_q.size() > 0) begin
            exp_d = fifo_q.pop_front();
            i_Tx_Ready = 1'b1;
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                tick();
                if (o_Wr_En === 1'b1) seen = 1'b1;
            end
            n_checks++;
            if (!seen) begin
                n_fail++; $display("FAIL drain_timeout: got no pulse expected data %h", exp_d);
                break;
            end
            if (o_Data_In !== exp_d) begin n_fail++; $display("FAIL drain_data: got %h expected %h", o_Data_In, exp_d); end
            i_Tx_Ready = 1'b0;
            tick(); tick();
        end
        n_checks++; if (o_Count !== 5'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", o_Count); end
        recover();
    endtask

    task automatic test_retry();
        logic [7:0] d0, d1;
        int gap;
        bit seen;
        d0 = 8'($urandom); d1 = 8'($urandom);
        i_Tx_Ready = 1'b1;
        i_Push_Valid = 1'b1; i_Push_Data = d0;
        tick();
        i_Push_Data = d1;
        tick();
        i_Push_Valid = 1'b0;
        n_checks++; if (o_Wr_En !== 1'b1 || o_Data_In !== d0) begin n_fail++; $display("FAIL retry_first: got wr %b data %h expected wr 1 data %h", o_Wr_En, o_Data_In, d0); end
        for (int r = 0; r < 3; r++) begin
            gap = 0;
            for (int k = 1; k <= 2 * (ACK_TIMEOUT + 2) && gap == 0; k++) begin
                tick();
                if (o_Wr_En === 1'b1) gap = k;
            end
            n_checks++; if (gap != ACK_TIMEOUT + 2) begin n_fail++; $display("FAIL retry_gap: got %0d expected %0d", gap, ACK_TIMEOUT + 2); end
            n_checks++; if (o_Data_In !== d0) begin n_fail++; $display("FAIL retry_data: got %h expected %h", o_Data_In, d0); end
            n_checks++; if (o_Count !== 5'd1) begin n_fail++; $display("FAIL retry_count: got %0d expected 1", o_Count); end
        end
        i_Tx_Ready = 1'b0;
        tick(); tick();
        i_Tx_Ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (o_Wr_En === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen || o_Data_In !== d1) begin n_fail++; $display("FAIL retry_next: got seen %b data %h expected data %h", seen, o_Data_In, d1); end
        n_checks++; if (o_Count !== 5'd0) begin n_fail++; $display("FAIL retry_final_count: got %0d expected 0", o_Count); end
        recover();
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        bit stray;
        i_Tx_Ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_Push_Valid = 1'b1; i_Push_Data = 8'($urandom);
            tick();
            if (i == 1) i_Tx_Ready = 1'b0;
        end
        i_Push_Valid = 1'b0;
        tick(); tick();
        n_checks++; if (o_Count !== 5'd5) begin n_fail++; $display("FAIL mid_queued: got %0d expected 5", o_Count); end
        i_Reset = 1'b1;
        tick();
        ovf_model = 0;
        i_Reset = 1'b0;
        n_checks++; if (o_Count !== 5'd0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", o_Count); end
        n_checks++; if (o_Empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %b expected 1", o_Empty); end
        n_checks++; if (o_Wr_En !== 1'b0) begin n_fail++; $display("FAIL mid_wr_en: got %b expected 0", o_Wr_En); end
        n_checks++; if (o_Overflow_Count !== exp_ovf()) begin n_fail++; $display("FAIL mid_ovf: got %0d expected %0d", o_Overflow_Count, exp_ovf()); end
        i_Tx_Ready = 1'b1;
        stray = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (o_Wr_En !== 1'b0) stray = 1'b1;
        end
        n_checks++; if (stray) begin n_fail++; $display("FAIL mid_stray_pulse: got pulse expected none"); end
        d = 8'($urandom);
        i_Push_Valid = 1'b1; i_Push_Data = d;
        tick();
        i_Push_Valid = 1'b0;
        tick();
        n_checks++; if (o_Wr_En !== 1'b1 || o_Data_In !== d) begin n_fail++; $display("FAIL mid_new_push: got wr %b data %h expected wr 1 data %h", o_Wr_En, o_Data_In, d); end
        recover();
    endtask

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge i_Clk_12MHz);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_retry();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
